conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Loads one 6x6 image (3-bit pixels) and six 2x2 kernels (3-bit taps), then sequences all 150 2x2 convolutions.
//  Each result goes into the clk1-side write port of the async FIFO toward the output domain.
//  Sits in the clk1 domain between the input interface and the CDC FIFO.
//  Owns the compute schedule and applies FIFO backpressure.
// PARAMETERS
//  IMG_N    6  image side in pixels
//  KER_N    2  kernel side in taps
//  NUM_KER  6  kernels per frame
//  PIX_W    3  pixel/tap width in bits, unsigned
//  OUT_W    8  result width in bits
// PORTS
//  clk1       in   1   single clock
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   row/kernel beat valid
//  in_row     in   18  pixel j at [3j+2:3j], j=0..5
//  in_kernel  in   12  k00 [2:0], k01 [5:3], k10 [8:6], k11 [11:9]
//  fifo_full  in   1   FIFO write side full
//  fifo_push  out  1   write strobe to FIFO
//  fifo_data  out  8   convolution result
//  busy       out  1   high whenever state != IDLE
//  done       out  1   one-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset: clock is one domain; reset is synchronous and active-high.
//   - rst high at a clk1 edge: state=IDLE and all counters=0.
//   - fifo_push=0, fifo_data=0, busy=0, done=0.
//   - Image/kernel buffers are not cleared.
//   - rst mid-LOAD or mid-COMPUTE aborts the frame. No further pushes are made for it.
//  FSM IDLE -> LOAD -> COMPUTE -> DONE -> IDLE.
//   - IDLE: in_valid=1 captures row 0 and kernel 0 in that same cycle, ld_cnt=1, go to LOAD.
//   - LOAD: each in_valid=1 cycle captures row[ld_cnt] and kernel[ld_cnt], then ld_cnt++.
//     A gap (in_valid=0) holds the count.
//     The capture with ld_cnt=5 goes to COMPUTE next cycle.
//   - COMPUTE: schedule order is kernel k (0..5) outer, out row r (0..4), out col c (0..4) inner.
//     fifo_push = (state==COMPUTE) & ~fifo_full. This is combinational, so no push is ever made into a full FIFO.
//     A push advances c, wrapping to r, then k.
//     fifo_full=1 holds all indices, with no push and no skip.
//     The push at k=5, r=4, c=4 goes to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//  Input handling:
//   - in_valid in COMPUTE or DONE is ignored.
//   - A new frame is accepted the cycle after DONE.
//  Arithmetic:
//   - fifo_data = P[r][c]*k00 + P[r][c+1]*k01 + P[r+1][c]*k10 + P[r+1][c+1]*k11, unsigned.
//   - Each product is 6 bits. The maximum sum is 196, so 8 bits hold it exactly with no saturation.
//   - fifo_data is combinational from registered buffers and indices.
//   - fifo_data=0 outside COMPUTE.
//  Latency and throughput:
//   - First push is in the cycle after the 6th load beat.
//   - With no stalls, all 150 pushes are on consecutive cycles, and done comes 1 cycle after the last push.
// CONFIGURATION
//  CONV_STALL_CNT_EN
//   - Defined: adds output port stall_cnt[15:0].
//     It counts cycles with state==COMPUTE and fifo_full=1, saturating at 16'hFFFF.
//     It clears on rst and on entry to LOAD, and holds its value after DONE.
//   - Undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Shared package conv_pkg:
//   - IMG_N/KER_N/NUM_KER/PIX_W/OUT_W localparams.
//   - State encoding (IDLE, LOAD, COMPUTE, DONE).
//   - Pixel and tap typedefs.
//  Sub-module conv_mac4: purely combinational 4-lane 3x3-bit multiply plus adder tree to 8 bits.
//  FSM, counters and buffers stay in conv_seq_ctrl.
// TESTING
//  1. All pixels 1, all taps 1, fifo_full=0
//     -> 150 consecutive pushes of 8'd4, busy high throughout, done 1 cycle after the last push.
//  2. All pixels 7, all taps 7
//     -> every push is 8'd196.
//     Ramp image P[r][c]=(r+c)%8, kernel k = {k00=k,k01=0,k10=0,k11=0}
//     -> values match the golden model in k,r,c order.
//  3. fifo_full=1 for 3 cycles after every 10th push
//     -> same 150-value sequence, no push while full, total cycles = 150+stalls.
//     With CONV_STALL_CNT_EN defined, stall_cnt equals the injected stall count.
//  4. in_valid with gaps (beats at cycles 0,1,4,5,6,9)
//     -> exactly 6 beats captured, first push the cycle after cycle 9, results correct.
//  5. rst pulsed during push #40
//     -> next cycle fifo_push=0, busy=0, done=0, no further pushes.
//     A new frame afterwards yields a full, correct 150 results.
//  6. in_valid toggling during COMPUTE and DONE with random data
//     -> ignored, results unchanged, no re-entry to LOAD until IDLE.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared parameters, state encoding and pixel/tap types for the 2x2 convolution sequencer.
// Optional feature macro used by this codebase: CONV_STALL_CNT_EN (see conv_seq_ctrl).
package conv_pkg;

  localparam int IMG_N   = 6;
  localparam int KER_N   = 2;
  localparam int NUM_KER = 6;
  localparam int PIX_W   = 3;
  localparam int OUT_W   = 8;
  localparam int OUT_N   = IMG_N - KER_N + 1;
  localparam int TAPS    = KER_N * KER_N;
  localparam int IDX_W   = 3;
  localparam int STALL_W = 16;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t             tap_t;
  typedef pix_t [IMG_N-1:0] row_t;   // pixel j at [3j+2:3j]
  typedef tap_t [TAPS-1:0]  kern_t;  // [0]=k00 [1]=k01 [2]=k10 [3]=k11
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_e;

  localparam idx_t LAST_LD  = idx_t'(NUM_KER - 1);
  localparam idx_t LAST_KER = idx_t'(NUM_KER - 1);
  localparam idx_t LAST_OUT = idx_t'(OUT_N - 1);

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Input-beat and FIFO-write bundle of the convolution sequencer.
// master = stimulus/upstream side, slave = conv_seq_ctrl.
interface conv_seq_ctrl_if;
  import conv_pkg::*;

  logic             in_valid;
  row_t             in_row;
  kern_t            in_kernel;
  logic             fifo_full;
  logic             fifo_push;
  logic [OUT_W-1:0] fifo_data;

  modport master (
    output in_valid, in_row, in_kernel, fifo_full,
    input  fifo_push, fifo_data
  );

  modport slave (
    input  in_valid, in_row, in_kernel, fifo_full,
    output fifo_push, fifo_data
  );

endinterface

// File: rtl/conv_mac4.sv
// Combinational 4-lane 3x3-bit multiply with a two-level adder tree; 4*49 = 196 fits 8 bits.
module conv_mac4
  import conv_pkg::*;
(
  input  kern_t            win,
  input  kern_t            tap,
  output logic [OUT_W-1:0] sum
);

  localparam int PROD_W = 2 * PIX_W;

  logic [PROD_W-1:0] prod [TAPS];
  logic [OUT_W-1:0]  sum_lo;
  logic [OUT_W-1:0]  sum_hi;

  // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod[i] = {{PIX_W{1'b0}}, win[i]} * {{PIX_W{1'b0}}, tap[i]};
    end
    sum_lo = OUT_W'(prod[0]) + OUT_W'(prod[1]);
    sum_hi = OUT_W'(prod[2]) + OUT_W'(prod[3]);
    sum    = sum_lo + sum_hi;
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Loads a 6x6 image plus six 2x2 kernels, then streams all 150 convolutions into a FIFO write port.
// Define CONV_STALL_CNT_EN to add the stall_cnt output (cycles spent in COMPUTE with fifo_full high).
module conv_seq_ctrl
  import conv_pkg::*;
(
  input  logic           clk1,
  input  logic           rst,
  conv_seq_ctrl_if.slave bus,
  output logic           busy,
  output logic           done
`ifdef CONV_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  state_e state_q, state_d;
  idx_t   ld_cnt_q, ld_cnt_d;
  idx_t   k_idx_q, k_idx_d;
  idx_t   r_idx_q, r_idx_d;
  idx_t   c_idx_q, c_idx_d;

  row_t   img_q  [IMG_N];
  row_t   img_d  [IMG_N];
  kern_t  taps_q [NUM_KER];
  kern_t  taps_d [NUM_KER];

  logic             load_en;
  idx_t             load_idx;
  logic             push;
  idx_t             r1_idx;
  idx_t             c1_idx;
  kern_t            win;
  logic [OUT_W-1:0] mac_sum;

  // The IDLE beat is row/kernel 0 regardless of ld_cnt.
  assign load_en  = bus.in_valid && (state_q == S_IDLE || state_q == S_LOAD);
  assign load_idx = (state_q == S_IDLE) ? '0 : ld_cnt_q;
  assign push     = (state_q == S_COMPUTE) && !bus.fifo_full;

  always_comb begin
    img_d  = img_q;
    taps_d = taps_q;
    if (load_en) begin
      img_d[load_idx]  = bus.in_row;
      taps_d[load_idx] = bus.in_kernel;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    k_idx_d  = k_idx_q;
    r_idx_d  = r_idx_q;
    c_idx_d  = c_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ld_cnt_d = idx_t'(1);
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (ld_cnt_q == LAST_LD) begin
            ld_cnt_d = '0;
            k_idx_d  = '0;
            r_idx_d  = '0;
            c_idx_d  = '0;
            state_d  = S_COMPUTE;
          end else begin
            ld_cnt_d = ld_cnt_q + 3'd1;
          end
        end
      end
      S_COMPUTE: begin
        // Column is innermost, then row, then kernel; a stalled cycle moves nothing.
        if (push) begin
          if (c_idx_q != LAST_OUT) begin
            c_idx_d = c_idx_q + 3'd1;
          end else begin
            c_idx_d = '0;
            if (r_idx_q != LAST_OUT) begin
              r_idx_d = r_idx_q + 3'd1;
            end else begin
              r_idx_d = '0;
              if (k_idx_q != LAST_KER) begin
                k_idx_d = k_idx_q + 3'd1;
              end else begin
                k_idx_d = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      k_idx_q  <= '0;
      r_idx_q  <= '0;
      c_idx_q  <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      k_idx_q  <= k_idx_d;
      r_idx_q  <= r_idx_d;
      c_idx_q  <= c_idx_d;
    end
  end

  // NOTE: image/kernel buffers carry no reset; they are always fully rewritten before COMPUTE reads them.
  always_ff @(posedge clk1) begin
    img_q  <= img_d;
    taps_q <= taps_d;
  end

  assign r1_idx = r_idx_q + 3'd1;
  assign c1_idx = c_idx_q + 3'd1;
  assign win    = {img_q[r1_idx][c1_idx], img_q[r1_idx][c_idx_q],
                   img_q[r_idx_q][c1_idx], img_q[r_idx_q][c_idx_q]};

  conv_mac4 u_mac (
    .win (win),
    .tap (taps_q[k_idx_q]),
    .sum (mac_sum)
  );

  assign bus.fifo_push = push;
  assign bus.fifo_data = (state_q == S_COMPUTE) ? mac_sum : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

`ifdef CONV_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Cleared on the IDLE->LOAD beat so it reflects only the current frame, then held after DONE.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.in_valid) begin
      stall_d = '0;
    end else if (state_q == S_COMPUTE && bus.fifo_full && stall_q != '1) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: randomized frames compared against a loop-based convolution model.
module tb_conv_seq_ctrl;

  logic clk1;
  logic rst;
  logic busy;
  logic done;
`ifdef CONV_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] img [6][6];
  logic [2:0] ker [6][4];

  conv_seq_ctrl_if bus ();

  conv_seq_ctrl dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
`ifdef CONV_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] pack_row(input int b);
    logic [17:0] v;
    for (int j = 0; j < 6; j++) v[3*j +: 3] = img[b][j];
    return v;
  endfunction

  function automatic logic [11:0] pack_ker(input int b);
    return {ker[b][3], ker[b][2], ker[b][1], ker[b][0]};
  endfunction

  task automatic fill_const(input int pv, input int kv);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) img[r][c] = 3'(pv);
    for (int k = 0; k < 6; k++)
      for (int t = 0; t < 4; t++) ker[k][t] = 3'(kv);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) img[r][c] = 3'((r + c) % 8);
    for (int k = 0; k < 6; k++) begin
      ker[k][0] = 3'(k);
      ker[k][1] = 3'd0;
      ker[k][2] = 3'd0;
      ker[k][3] = 3'd0;
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) img[r][c] = 3'($urandom_range(0, 7));
    for (int k = 0; k < 6; k++)
      for (int t = 0; t < 4; t++) ker[k][t] = 3'($urandom_range(0, 7));
  endtask

  // Runs one frame from the cycle its first beat is driven; entered and left at posedge+1.
  task automatic run_frame(input bit use_gaps, input bit stalls, input bit noise, input int abort_at);
    int  sched [6];
    int  exp_q [$];
    int  cyc, beat, pushes, stalls_n, stall_left, first_push, last_push, done_cyc, extra;
    bit  finished, aborted, busy_ok;

    for (int k = 0; k < 6; k++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          exp_q.push_back(int'(img[r][c])   * int'(ker[k][0]) + int'(img[r][c+1])   * int'(ker[k][1]) +
                          int'(img[r+1][c]) * int'(ker[k][2]) + int'(img[r+1][c+1]) * int'(ker[k][3]));

    if (use_gaps) sched = '{0, 1, 4, 5, 6, 9};
    else          sched = '{0, 1, 2, 3, 4, 5};

    cyc = 0; beat = 0; pushes = 0; stalls_n = 0; stall_left = 0;
    first_push = -1; last_push = -1; done_cyc = -1;
    finished = 0; aborted = 0; busy_ok = 1;

    while (!finished && cyc < 1000) begin
      if (beat < 6 && cyc == sched[beat]) begin
        bus.in_valid  = 1'b1;
        bus.in_row    = pack_row(beat);
        bus.in_kernel = pack_ker(beat);
        beat++;
      end else begin
        bus.in_valid  = (noise && beat == 6) ? 1'($urandom) : 1'b0;
        bus.in_row    = 18'($urandom);
        bus.in_kernel = 12'($urandom);
      end
      if (stall_left > 0) begin
        bus.fifo_full = 1'b1;
        stall_left--;
        stalls_n++;
      end else begin
        bus.fifo_full = 1'b0;
      end

      @(negedge clk1);
      if (cyc > sched[0] && !busy) busy_ok = 0;
      if (bus.fifo_push) begin
        pushes++;
        check("push_while_full", int'(bus.fifo_full), 0);
        if (exp_q.size() == 0) check("extra_push", pushes, 150);
        else                   check("data", int'(bus.fifo_data), exp_q.pop_front());
        if (first_push < 0) first_push = cyc;
        last_push = cyc;
        if (stalls && pushes % 10 == 0 && pushes < 150) stall_left = 3;
        if (pushes == abort_at) begin
          rst      = 1'b1;
          aborted  = 1;
          finished = 1;
        end
      end
      if (done && !aborted) begin
        done_cyc = cyc;
        finished = 1;
      end
      @(posedge clk1);
      #1;
      cyc++;
    end

    if (!finished) check("frame_timeout", 1, 0);
    check("busy_held", int'(busy_ok), 1);
    check("first_push_cycle", first_push, sched[5] + 1);

    if (aborted) begin
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.fifo_full = 1'b0;
      @(negedge clk1);
      check("abort_push", int'(bus.fifo_push), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_data", int'(bus.fifo_data), 0);
`ifdef CONV_STALL_CNT_EN
      check("abort_stall_cnt", int'(stall_cnt), 0);
`endif
      extra = 0;
      repeat (20) begin
        @(posedge clk1);
        #1;
        @(negedge clk1);
        if (bus.fifo_push || busy) extra++;
      end
      check("post_abort_activity", extra, 0);
    end else if (finished) begin
      bus.in_valid  = 1'b0;
      bus.fifo_full = 1'b0;
      check("push_count", pushes, 150);
      check("done_latency", done_cyc, last_push + 1);
      check("total_cycles", last_push - first_push + 1, 150 + stalls_n);
`ifdef CONV_STALL_CNT_EN
      check("stall_cnt", int'(stall_cnt), stalls_n);
`endif
      @(negedge clk1);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      check("idle_push", int'(bus.fifo_push), 0);
    end
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_kernel = '0;
    bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("reset_push", int'(bus.fifo_push), 0);
    check("reset_data", int'(bus.fifo_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge clk1);
    #1;
    rst = 1'b0;

    fill_const(1, 1); run_frame(1'b0, 1'b0, 1'b0, 0);
    fill_const(7, 7); run_frame(1'b0, 1'b0, 1'b0, 0);
    fill_ramp();      run_frame(1'b0, 1'b0, 1'b0, 0);
    fill_random();    run_frame(1'b0, 1'b1, 1'b0, 0);
    fill_random();    run_frame(1'b1, 1'b0, 1'b0, 0);
    fill_random();    run_frame(1'b0, 1'b0, 1'b0, 40);
    fill_random();    run_frame(1'b0, 1'b0, 1'b0, 0);
    fill_random();    run_frame(1'b0, 1'b0, 1'b1, 0);
    fill_random();    run_frame(1'b1, 1'b1, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
